regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameters: none; all widths fixed (32-bit data, 5-bit register number, 32 registers).
REQ-002 Clock and reset SHALL be clk and reset; reset is synchronous, active-high.
REQ-003 clk  input  1  clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 a_valid  input  1  requester A (ALU writeback) holds a write.
REQ-006 a_regnum  input  5  requester A destination register.
REQ-007 a_data  input  32  requester A write data.
REQ-008 a_ready  output  1  requester A write accepted this cycle.
REQ-009 b_valid  input  1  requester B (load writeback) holds a write.
REQ-010 b_regnum  input  5  requester B destination register.
REQ-011 b_data  input  32  requester B write data.
REQ-012 b_ready  output  1  requester B write accepted this cycle.
REQ-013 writeenable  output  1  register-file write enable, registered.
REQ-014 wr_regnum  output  5  register-file write register number, registered.
REQ-015 wr_data  output  32  register-file write data, registered.
REQ-016 rsv_en  input  1  reserve (mark pending) register rsv_regnum.
REQ-017 rsv_regnum  input  5  register to reserve.
REQ-018 rd1_regnum, rd2_regnum  input  5 each  registers being read by issue logic.
REQ-019 rd1_pending, rd2_pending  output  1 each  queried register has an outstanding write.

Function
REQ-020 Handshake: a transfer occurs on a requester when its valid and ready are both high at a rising edge; ready SHALL be combinational from valids and arbitration state, never high while its valid is low.
REQ-021 At most one of a_ready/b_ready SHALL be high in any cycle; with exactly one valid, that requester SHALL be granted.
REQ-022 Both valid: winner per arbitration policy (REQ-033/034); loser holds valid and inputs stable until granted.
REQ-023 Latency: a transfer at edge N SHALL drive writeenable=1, wr_regnum, wr_data during cycle N..N+1 (regfile writes at edge N+1); no transfer -> writeenable=0 next cycle.
REQ-024 Transfer with regnum 0: SHALL be accepted (ready high) but discarded; writeenable SHALL stay 0 for it.
REQ-025 Throughput: one transfer per cycle sustained; no back-pressure from the write port.
REQ-026 Scoreboard: 32 pending bits; rsv_en=1 at an edge SHALL set pending[rsv_regnum] at that edge; rsv_regnum 0 ignored, pending[0] constantly 0.
REQ-027 Pending bit SHALL clear at the edge where writeenable=1 commits to wr_regnum.
REQ-028 Simultaneous set and clear of the same register at one edge: set wins (bit stays 1).
REQ-029 rdN_pending SHALL be combinational = pending[rdN_regnum]; no bypass of same-cycle set or clear.

Reset
REQ-030 While reset=1 at an edge: writeenable, wr_regnum, wr_data SHALL become 0; all pending bits cleared; arbitration pointer set to favour A.
REQ-031 a_ready and b_ready SHALL be 0 during any cycle reset is high; no transfer occurs.
REQ-032 Reset mid-operation: a write accepted at the previous edge but not yet committed SHALL be dropped (writeenable forced 0).

Configuration
REQ-033 Macro WB_RR_ARB_EN defined: round-robin; a one-bit pointer SHALL flip to the non-winning requester after every contested grant, and uncontested grants leave it unchanged.
REQ-034 WB_RR_ARB_EN undefined: fixed priority, A always wins when both valid; pointer logic absent.

Verification
REQ-035 A writes r5=0x1234_5678 alone -> a_ready same cycle, next cycle writeenable=1, wr_regnum=5, wr_data=0x12345678.
REQ-036 A and B valid for 4 cycles (r3/r4): with WB_RR_ARB_EN grants A,B,A,B; without, A each cycle and b_ready=0.
REQ-037 B writes r0=0xFFFF_FFFF -> b_ready=1, writeenable stays 0, pending[0] stays 0.
REQ-038 rsv_en r7, then rd1_regnum=7 -> rd1_pending=1; A write r7 commits -> rd1_pending=0 the following cycle; rsv r7 on the commit edge -> stays 1.
REQ-039 A write accepted, reset asserted next cycle -> writeenable=0, all rdN_pending=0, a_ready=0 during reset.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file writeback arbiter (ALU vs load) with pending-write scoreboard
// Define WB_RR_ARB_EN for round-robin arbitration; default build is fixed priority with A winning.
module regfile_wb_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  input  logic [4:0]  a_regnum,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_regnum,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic        writeenable,
  output logic [4:0]  wr_regnum,
  output logic [31:0] wr_data,
  input  logic        rsv_en,
  input  logic [4:0]  rsv_regnum,
  input  logic [4:0]  rd1_regnum,
  input  logic [4:0]  rd2_regnum,
  output logic        rd1_pending,
  output logic        rd2_pending
);

  logic        a_wins;
  logic        grant_a;
  logic        grant_b;
  logic [31:0] pending;
  logic [31:0] pending_next;

`ifdef WB_RR_ARB_EN
  logic favor_b;

  // After a contested grant the pointer moves to the requester that lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      favor_b <= 1'b0;
    end else if (a_valid && b_valid) begin
      favor_b <= grant_a;
    end
  end

  assign a_wins = !favor_b;
`else
  assign a_wins = 1'b1;
`endif

  assign grant_a = !reset && a_valid && (!b_valid || a_wins);
  assign grant_b = !reset && b_valid && (!a_valid || !a_wins);
  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // Writes to r0 are accepted but never reach the register file.
  always_ff @(posedge clk) begin
    if (reset) begin
      writeenable <= 1'b0;
      wr_regnum   <= 5'd0;
      wr_data     <= 32'd0;
    end else begin
      writeenable <= (grant_a && (a_regnum != 5'd0)) || (grant_b && (b_regnum != 5'd0));
      if (grant_a) begin
        wr_regnum <= a_regnum;
        wr_data   <= a_data;
      end else if (grant_b) begin
        wr_regnum <= b_regnum;
        wr_data   <= b_data;
      end
    end
  end

  // Clear on commit first, then set, so a reservation on the commit edge survives.
  always_comb begin
    pending_next = pending;
    if (writeenable) begin
      pending_next[wr_regnum] = 1'b0;
    end
    if (rsv_en) begin
      pending_next[rsv_regnum] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 32'd0;
    end else begin
      pending <= pending_next;
    end
  end

  assign rd1_pending = pending[rd1_regnum];
  assign rd2_pending = pending[rd2_regnum];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
// Vector table, directed corner sequences and randomized traffic against a behavioural model.
module tb_regfile_wb_arbiter;

`ifdef WB_RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        a_valid;
  logic [4:0]  a_regnum;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_regnum;
  logic [31:0] b_data;
  logic        b_ready;
  logic        writeenable;
  logic [4:0]  wr_regnum;
  logic [31:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_regnum;
  logic [4:0]  rd1_regnum;
  logic [4:0]  rd2_regnum;
  logic        rd1_pending;
  logic        rd2_pending;

  regfile_wb_arbiter dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_regnum(a_regnum), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_regnum(b_regnum), .b_data(b_data), .b_ready(b_ready),
    .writeenable(writeenable), .wr_regnum(wr_regnum), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_regnum(rsv_regnum),
    .rd1_regnum(rd1_regnum), .rd2_regnum(rd2_regnum),
    .rd1_pending(rd1_pending), .rd2_pending(rd2_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  // Reference model: the register file write port as seen one cycle later, plus a pending set.
  bit        m_we;
  bit [4:0]  m_rn;
  bit [31:0] m_data;
  bit        m_pend [32];
  bit        m_favor_b;
  bit        m_ga;
  bit        m_gb;
  logic      s_ar, s_br, s_p1, s_p2;

  typedef struct {
    logic        av;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  br;
    logic [31:0] bd;
    logic        ea;
    logic        eb;
    logic        ewe;
    logic [4:0]  ern;
    logic [31:0] ed;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_we = 0; m_rn = 0; m_data = 0; m_favor_b = 0;
    for (int i = 0; i < 32; i++) m_pend[i] = 0;
  endtask

  // Entered at posedge+1 with inputs applied; returns at the next posedge+1.
  task automatic cycle();
    bit ga, gb, rst_s;
    #3;
    ga = 0; gb = 0;
    if (!reset) begin
      if (a_valid && !b_valid) ga = 1;
      else if (b_valid && !a_valid) gb = 1;
      else if (a_valid && b_valid) begin
        if (RR && m_favor_b) gb = 1;
        else ga = 1;
      end
    end
    s_ar = a_ready; s_br = b_ready; s_p1 = rd1_pending; s_p2 = rd2_pending;
    chk("a_ready", {31'd0, a_ready}, {31'd0, ga});
    chk("b_ready", {31'd0, b_ready}, {31'd0, gb});
    chk("rd1_pending", {31'd0, rd1_pending}, {31'd0, m_pend[rd1_regnum]});
    chk("rd2_pending", {31'd0, rd2_pending}, {31'd0, m_pend[rd2_regnum]});
    rst_s = reset;
    m_ga = ga; m_gb = gb;
    @(posedge clk);
    if (rst_s) begin
      model_reset();
    end else begin
      if (m_we) m_pend[m_rn] = 0;
      if (rsv_en && rsv_regnum != 0) m_pend[rsv_regnum] = 1;
      if (RR && a_valid && b_valid) m_favor_b = ga;
      m_we = 0;
      if (ga && a_regnum != 0) begin m_we = 1; m_rn = a_regnum; m_data = a_data; end
      if (gb && b_regnum != 0) begin m_we = 1; m_rn = b_regnum; m_data = b_data; end
    end
    #1;
    chk("writeenable", {31'd0, writeenable}, {31'd0, m_we});
    if (m_we || rst_s) begin
      chk("wr_regnum", {27'd0, wr_regnum}, {27'd0, m_rn});
      chk("wr_data", wr_data, m_data);
    end
  endtask

  task automatic idle_inputs();
    a_valid = 0; a_regnum = 0; a_data = 0;
    b_valid = 0; b_regnum = 0; b_data = 0;
    rsv_en = 0; rsv_regnum = 0; rd1_regnum = 0; rd2_regnum = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    cycle();
    reset = 0;
  endtask

  initial begin
    vecs[0] = '{1, 5'd5,  32'h1234_5678, 0, 5'd0, 32'h0,         1, 0, 1, 5'd5, 32'h1234_5678};
    vecs[1] = '{0, 5'd0,  32'h0,         1, 5'd0, 32'hFFFF_FFFF, 0, 1, 0, 5'd0, 32'h0};
    vecs[2] = '{0, 5'd0,  32'h0,         0, 5'd0, 32'h0,         0, 0, 0, 5'd0, 32'h0};
    vecs[3] = '{0, 5'd0,  32'h0,         1, 5'd9, 32'hDEAD_BEEF, 0, 1, 1, 5'd9, 32'hDEAD_BEEF};
    vecs[4] = '{1, 5'd0,  32'hCAFE_0000, 0, 5'd0, 32'h0,         1, 0, 0, 5'd0, 32'h0};
    vecs[5] = '{1, 5'd3,  32'h0000_0033, 1, 5'd4, 32'h0000_0044, 1, 0, 1, 5'd3, 32'h0000_0033};

    idle_inputs();
    reset = 1;
    @(posedge clk);
    #1;
    model_reset();
    cycle();
    chk("reset_writeenable", {31'd0, writeenable}, 32'd0);
    chk("reset_wr_data", wr_data, 32'd0);
    reset = 0;

    foreach (vecs[i]) begin
      a_valid = vecs[i].av; a_regnum = vecs[i].ar; a_data = vecs[i].ad;
      b_valid = vecs[i].bv; b_regnum = vecs[i].br; b_data = vecs[i].bd;
      cycle();
      chk("vec_a_ready", {31'd0, s_ar}, {31'd0, vecs[i].ea});
      chk("vec_b_ready", {31'd0, s_br}, {31'd0, vecs[i].eb});
      chk("vec_writeenable", {31'd0, writeenable}, {31'd0, vecs[i].ewe});
      if (vecs[i].ewe) begin
        chk("vec_wr_regnum", {27'd0, wr_regnum}, {27'd0, vecs[i].ern});
        chk("vec_wr_data", wr_data, vecs[i].ed);
      end
    end
    idle_inputs();
    rd2_regnum = 0;
    cycle();
    chk("r0_never_pending", {31'd0, s_p2}, 32'd0);

    // Contested requesters held for four cycles.
    do_reset();
    a_valid = 1; a_regnum = 5'd3; a_data = 32'hA3;
    b_valid = 1; b_regnum = 5'd4; b_data = 32'hB4;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("contest_a_ready", {31'd0, s_ar}, {31'd0, (!RR || (k % 2 == 0))});
      chk("contest_b_ready", {31'd0, s_br}, {31'd0, (RR && (k % 2 == 1))});
      chk("contest_wr_regnum", {27'd0, wr_regnum}, (RR && (k % 2 == 1)) ? 32'd4 : 32'd3);
    end

    // Scoreboard set / commit-clear / set-wins-over-clear.
    do_reset();
    rsv_en = 1; rsv_regnum = 5'd7;
    cycle();
    rsv_en = 0; rd1_regnum = 5'd7;
    a_valid = 1; a_regnum = 5'd7; a_data = 32'h77;
    cycle();
    chk("r7_reserved", {31'd0, s_p1}, 32'd1);
    a_valid = 0;
    rsv_en = 1; rsv_regnum = 5'd0;
    cycle();
    chk("r7_pending_until_commit", {31'd0, s_p1}, 32'd1);
    rsv_en = 0; rd2_regnum = 5'd0;
    cycle();
    chk("r7_cleared_after_commit", {31'd0, s_p1}, 32'd0);
    chk("r0_reserve_ignored", {31'd0, s_p2}, 32'd0);
    rsv_en = 1; rsv_regnum = 5'd7;
    cycle();
    rsv_en = 0;
    a_valid = 1; a_regnum = 5'd7; a_data = 32'h78;
    cycle();
    a_valid = 0;
    rsv_en = 1; rsv_regnum = 5'd7;
    cycle();
    rsv_en = 0;
    cycle();
    chk("r7_set_wins_on_commit", {31'd0, s_p1}, 32'd1);

    // Reset immediately after an accepted write.
    do_reset();
    rsv_en = 1; rsv_regnum = 5'd9;
    a_valid = 1; a_regnum = 5'd12; a_data = 32'h1212;
    cycle();
    chk("pre_reset_accept", {31'd0, s_ar}, 32'd1);
    rsv_en = 0;
    reset = 1;
    cycle();
    chk("reset_blocks_a_ready", {31'd0, s_ar}, 32'd0);
    chk("reset_drops_write", {31'd0, writeenable}, 32'd0);
    reset = 0; a_valid = 0; rd1_regnum = 5'd9; rd2_regnum = 5'd12;
    cycle();
    chk("reset_clears_rd1", {31'd0, s_p1}, 32'd0);
    chk("reset_clears_rd2", {31'd0, s_p2}, 32'd0);

    // Random traffic; a requester not granted keeps its request stable.
    do_reset();
    m_ga = 0; m_gb = 0;
    for (int i = 0; i < 500; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      if (!a_valid || m_ga) begin
        a_valid = $urandom_range(0, 1);
        a_regnum = 5'($urandom_range(0, 15));
        a_data = $urandom;
      end
      if (!b_valid || m_gb) begin
        b_valid = $urandom_range(0, 1);
        b_regnum = 5'($urandom_range(0, 15));
        b_data = $urandom;
      end
      rsv_en = ($urandom_range(0, 2) == 0);
      rsv_regnum = 5'($urandom_range(0, 15));
      rd1_regnum = 5'($urandom_range(0, 15));
      rd2_regnum = 5'($urandom_range(0, 31));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
